// File: rtl/io_pattern_bank.sv
// io_pattern_bank: multi-channel output-pattern generator for board bring-up.
// A free-running prescaler emits a tick every 2^LOG2DELAY cycles; on each tick
// the pattern register (which directly drives led_o) advances according to the
// active mode, or loads the start value of a newly requested mode.
// Optional differential output pair is built only when IO_PATTERN_BANK_DIFF_EN
// is defined; otherwise diff_p/diff_n are tied to 0/1.
module io_pattern_bank #(
   parameter int unsigned CHANNELS  = 4,
   parameter int unsigned LOG2DELAY = 25
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [1:0]          mode,
   input  logic                mode_valid,
   output logic                mode_ready,
   input  logic [CHANNELS-1:0] oe_mask,
   output logic [CHANNELS-1:0] led_o,
   output logic [CHANNELS-1:0] led_t,
   output logic                tick,
   output logic                diff_p,
   output logic                diff_n
);

   typedef enum logic [1:0] {
      ModeCount  = 2'd0,
      ModeWalk   = 2'd1,
      ModeBounce = 2'd2,
      ModeOff    = 2'd3
   } mode_e;

   logic [LOG2DELAY-1:0] prescaler_q;
   logic                 tick_q;
   mode_e                mode_q, mode_d;
   mode_e                pend_mode_q;
   logic                 pend_vld_q;
   logic                 dir_up_q, dir_up_d;
   logic [CHANNELS-1:0]  pattern_q, pattern_d;
   logic [CHANNELS-1:0]  led_t_q;
   logic                 accept;

   // A new request is only taken while nothing is pending.
   assign accept     = mode_valid & ~pend_vld_q;
   assign mode_ready = ~pend_vld_q;
   assign tick       = tick_q;
   assign led_o      = pattern_q;
   assign led_t      = led_t_q;

   // Next pattern: hold between ticks; on a tick either load a pending mode's
   // start value or advance in the active mode.
   always_comb begin
      pattern_d = pattern_q;
      dir_up_d  = dir_up_q;
      mode_d    = mode_q;
      if (tick_q) begin
         if (pend_vld_q) begin
            mode_d   = pend_mode_q;
            dir_up_d = 1'b1;
            unique case (pend_mode_q)
               ModeWalk, ModeBounce: pattern_d = CHANNELS'(1);
               default:              pattern_d = '0;
            endcase
         end else begin
            unique case (mode_q)
               ModeCount: pattern_d = pattern_q + CHANNELS'(1);
               ModeWalk:  pattern_d = (pattern_q << 1) | (pattern_q >> (CHANNELS - 1));
               ModeBounce: begin
                  if (CHANNELS == 1) begin
                     pattern_d = pattern_q;
                  end else if (dir_up_q) begin
                     // Reverse at the top end instead of shifting out.
                     if (pattern_q[CHANNELS-1]) begin
                        pattern_d = pattern_q >> 1;
                        dir_up_d  = 1'b0;
                     end else begin
                        pattern_d = pattern_q << 1;
                     end
                  end else begin
                     if (pattern_q[0]) begin
                        pattern_d = pattern_q << 1;
                        dir_up_d  = 1'b1;
                     end else begin
                        pattern_d = pattern_q >> 1;
                     end
                  end
               end
               default: pattern_d = '0;
            endcase
         end
      end
   end

   // Prescaler, tick, mode handshake, pattern and tristate registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prescaler_q <= '0;
         tick_q      <= 1'b0;
         mode_q      <= ModeCount;
         pend_mode_q <= ModeCount;
         pend_vld_q  <= 1'b0;
         dir_up_q    <= 1'b1;
         pattern_q   <= '0;
         led_t_q     <= '1;
      end else begin
         prescaler_q <= prescaler_q + LOG2DELAY'(1);
         tick_q      <= &prescaler_q;
         mode_q      <= mode_d;
         dir_up_q    <= dir_up_d;
         pattern_q   <= pattern_d;
         led_t_q     <= ~oe_mask;
         // A pending request is consumed on a tick; a request accepted on the
         // same edge as a tick stays pending until the following tick.
         if (accept) begin
            pend_vld_q  <= 1'b1;
            pend_mode_q <= mode_e'(mode);
         end else if (tick_q) begin
            pend_vld_q <= 1'b0;
         end
      end
   end

`ifdef IO_PATTERN_BANK_DIFF_EN
   logic diff_p_q;

   // Differential pair tracks pattern bit 0, updated on the same edge as led_o.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         diff_p_q <= 1'b0;
      end else begin
         diff_p_q <= pattern_d[0];
      end
   end

   assign diff_p = diff_p_q;
   assign diff_n = ~diff_p_q;
`else
   assign diff_p = 1'b0;
   assign diff_n = 1'b1;
`endif

endmodule

// File: tb/tb_io_pattern_bank.sv
// Randomized self-checking bench for io_pattern_bank (CHANNELS=4, LOG2DELAY=2).
// The reference model counts cycles since reset release to derive ticks and
// tracks patterns as a counter value or a one-hot position/direction.
module tb_io_pattern_bank;

   localparam int unsigned Ch = 4;
   localparam int unsigned L2 = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [1:0]    mode;
   logic          mode_valid;
   logic          mode_ready;
   logic [Ch-1:0] oe_mask;
   logic [Ch-1:0] led_o;
   logic [Ch-1:0] led_t;
   logic          tick;
   logic          diff_p;
   logic          diff_n;

   always #5 clk = ~clk;

   io_pattern_bank #(
      .CHANNELS  (Ch),
      .LOG2DELAY (L2)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .mode       (mode),
      .mode_valid (mode_valid),
      .mode_ready (mode_ready),
      .oe_mask    (oe_mask),
      .led_o      (led_o),
      .led_t      (led_t),
      .tick       (tick),
      .diff_p     (diff_p),
      .diff_n     (diff_n)
   );

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   // Reference model state.
   int unsigned m_n;        // edges since reset release
   int unsigned m_mode;
   int unsigned m_pend_mode;
   bit          m_pend;
   int unsigned m_led;
   int unsigned m_pos;
   bit          m_up;
   bit          m_tick;
   int unsigned m_ledt;

   task automatic model_reset();
      m_n = 0; m_mode = 0; m_pend_mode = 0; m_pend = 0;
      m_led = 0; m_pos = 0; m_up = 1; m_tick = 0; m_ledt = (1 << Ch) - 1;
   endtask

   task automatic model_step(input bit v, input int unsigned md, input int unsigned oe);
      bit acc;
      acc = v && !m_pend;
      if (m_tick) begin
         if (m_pend) begin
            m_mode = m_pend_mode;
            m_pend = 0;
            m_pos  = 0;
            m_up   = 1;
            m_led  = (m_mode == 1 || m_mode == 2) ? 1 : 0;
         end else begin
            case (m_mode)
               0: m_led = (m_led + 1) % (1 << Ch);
               1: begin
                  m_pos = (m_pos + 1) % Ch;
                  m_led = 1 << m_pos;
               end
               2: begin
                  if (m_up) begin
                     if (m_pos == Ch - 1) begin m_up = 0; m_pos = m_pos - 1; end
                     else m_pos = m_pos + 1;
                  end else begin
                     if (m_pos == 0) begin m_up = 1; m_pos = 1; end
                     else m_pos = m_pos - 1;
                  end
                  m_led = 1 << m_pos;
               end
               default: m_led = 0;
            endcase
         end
      end
      if (acc) begin
         m_pend      = 1;
         m_pend_mode = md;
      end
      m_ledt = (~oe) & ((1 << Ch) - 1);
      m_n++;
      m_tick = (m_n % (1 << L2)) == 0;
   endtask

   task automatic compare_all();
      check_val("led_o", 32'(led_o), m_led);
      check_val("led_t", 32'(led_t), m_ledt);
      check_val("tick", 32'(tick), 32'(m_tick));
      check_val("mode_ready", 32'(mode_ready), 32'(!m_pend));
`ifdef IO_PATTERN_BANK_DIFF_EN
      check_val("diff_p", 32'(diff_p), m_led & 1);
      check_val("diff_n", 32'(diff_n), 32'((m_led & 1) == 0));
`else
      check_val("diff_p", 32'(diff_p), 32'd0);
      check_val("diff_n", 32'(diff_n), 32'd1);
`endif
   endtask

   initial begin
      bit          v;
      int unsigned md;
      int unsigned oe;
      rst_n      = 1'b0;
      mode       = 2'd0;
      mode_valid = 1'b0;
      oe_mask    = '0;
      oe         = 0;
      model_reset();
      repeat (2) @(negedge clk);
      compare_all();
      rst_n = 1'b1;

      for (int i = 0; i < 3000; i++) begin
         compare_all();
         // Occasional asynchronous reset mid-run: outputs must clear at once.
         if (i > 100 && $urandom_range(0, 299) == 0) begin
            rst_n      = 1'b0;
            mode_valid = 1'b0;
            #1;
            model_reset();
            m_ledt = (1 << Ch) - 1;
            compare_all();
            @(posedge clk);
            @(negedge clk);
            rst_n = 1'b1;
            oe    = 0;
            continue;
         end
         // Leave COUNT undisturbed long enough to see the 4'hF -> 4'h0 wrap.
         v  = (i >= 80) && ($urandom_range(0, 5) == 0);
         md = $urandom_range(0, 3);
         if ($urandom_range(0, 3) == 0) oe = $urandom_range(0, (1 << Ch) - 1);
         mode_valid = v;
         mode       = md[1:0];
         oe_mask    = oe[Ch-1:0];
         @(posedge clk);
         model_step(v, md, oe);
         @(negedge clk);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/io_pattern_bank.md
# io_pattern_bank

Parametrised multi-channel output-pattern generator for board bring-up and IO-constraint test designs. A free-running prescaler drives a CHANNELS-wide pattern register through selectable modes (binary count, walking one, bounce, off). Each channel drives a registered output with its own tristate control, plus an optional differential pair. The block sits between the clock and the device output buffers (OBUF/OBUFT/OBUFTDS) at the top of the design.

## Interface
- CHANNELS, 4, number of output channels; legal range 1..32
- LOG2DELAY, 25, prescaler width; tick period = 2^LOG2DELAY cycles; legal range 1..31

- clk  in  1  system clock; all state is on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- mode  in  2  requested mode: 0 COUNT, 1 WALK, 2 BOUNCE, 3 OFF
- mode_valid  in  1  mode request valid
- mode_ready  out  1  block can accept a mode request
- oe_mask  in  CHANNELS  per-channel output enable, 1 = drive
- led_o  out  CHANNELS  pattern outputs, to buffer I pins
- led_t  out  CHANNELS  tristate controls, 1 = high-Z, to OBUFT T pins
- tick  out  1  one-cycle pulse at each prescaler wrap
- diff_p  out  1  differential true output
- diff_n  out  1  differential complement output

## Operation
- Reset values:
  - prescaler = 0, active mode = COUNT, pattern = 0, led_o = 0
  - led_t = all 1, tick = 0, mode_ready = 1
  - diff_p = 0, diff_n = 1
  - direction = up, no request pending
- The prescaler is a LOG2DELAY-bit up-counter that wraps.
- tick is registered. It is high for the one cycle after the prescaler holds all-ones.
- Pattern register:
  - It updates at the edge where tick is high.
  - led_o = pattern, registered, so new values appear one cycle after the tick cycle.
- Mode behaviour at each tick:
  - COUNT: pattern += 1 modulo 2^CHANNELS.
  - WALK: one-hot rotate left; bit CHANNELS-1 wraps to bit 0.
  - BOUNCE: one-hot shift in the current direction. Direction flips when the 1 reaches bit CHANNELS-1 (going up) or bit 0 (going down). With CHANNELS=1 the pattern stays 1.
  - OFF: pattern = 0.
- Mode handshake:
  - A request is accepted when mode_valid && mode_ready. The value is captured into a pending register and mode_ready drops the next cycle.
  - The pending mode takes effect at the next tick. On that tick the pattern loads the mode's start value instead of advancing: COUNT 0, WALK 1, BOUNCE 1 with direction up, OFF 0.
  - mode_ready reasserts the cycle after that tick.
  - If acceptance and tick occur in the same cycle, the mode applies at the following tick, not the current one.
  - mode_valid while mode_ready is low is ignored; the requester must hold it.
- led_t = ~oe_mask, registered with 1-cycle latency and independent of tick.
- Differential pair: diff_p = pattern[0] and diff_n = ~pattern[0], both registered alongside led_o.
- Asserting rst_n low mid-operation immediately forces all reset values, including discarding any pending request.

## Timing
- Tick period: exactly 2^LOG2DELAY cycles. The first tick occurs at cycle 2^LOG2DELAY after reset release.
- Latency from tick high to the new led_o / diff_p / diff_n: 1 cycle.
- Latency from oe_mask change to led_t: 1 cycle.
- Mode latency from accept to effect: 1 to 2^LOG2DELAY+1 cycles, depending on prescaler phase.
- Back-to-back requests: at most one mode change per tick period.

## Configuration
- IO_PATTERN_BANK_DIFF_EN
  - Defined: diff_p/diff_n behave as in Operation.
  - Undefined: no differential logic is built, and the ports are held at constant diff_p = 0, diff_n = 1 from reset onward.

## Test plan
All scenarios use CHANNELS=4, LOG2DELAY=2.
- Reset release, mode COUNT → tick high at cycles 4, 8, 12; led_o = 1, 2, 3 at cycles 5, 9, 13; led_t = 4'hF until oe_mask applied.
- COUNT run of 16 ticks → led_o wraps from 4'hF to 4'h0.
- Request WALK accepted at cycle 2 → mode_ready low until the tick at cycle 4; led_o = 4'b0001 at cycle 5, then 0010, 0100, 1000, 0001.
- Request BOUNCE accepted in the same cycle as a tick → mode applies at the next tick; led_o sequence 0001, 0010, 0100, 1000, 0100, 0010, 0001.
- oe_mask = 4'b0101 → led_t = 4'b1010 one cycle later; rst_n pulsed low mid-WALK → led_o = 0, led_t = 4'hF, mode_ready = 1 immediately, and COUNT resumes after release.
- With IO_PATTERN_BANK_DIFF_EN: diff_n == ~diff_p every cycle and diff_p == led_o[0]. Without it: diff_p = 0 and diff_n = 1 always.
